// File: rtl/qarma_sched.sv
// Two-requester front end for a shared combinational QARMA-128 core.
// Round-robin grant, fixed settle latency, key zeroization after each response.
module qarma_sched #(
    parameter int unsigned WAIT_CYC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_enc,
    input  logic [255:0] req0_key,
    input  logic [127:0] req0_pt,
    input  logic [127:0] req0_tweak,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_enc,
    input  logic [255:0] req1_key,
    input  logic [127:0] req1_pt,
    input  logic [127:0] req1_tweak,
    output logic         core_enc,
    output logic [255:0] core_K,
    output logic [127:0] core_P,
    output logic [127:0] core_T,
    input  logic [127:0] core_C,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_id,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         last_id_q, last_id_d;
    logic         core_enc_q, core_enc_d;
    logic [255:0] core_k_q, core_k_d;
    logic [127:0] core_p_q, core_p_d;
    logic [127:0] core_t_q, core_t_d;
    logic [127:0] rsp_data_q, rsp_data_d;
    logic         rsp_id_q, rsp_id_d;

    logic idle;
    logic gnt1;

    // rst_n gates the readies so nothing is offered while reset is held
    assign idle       = (state_q == S_IDLE) && rst_n;
    assign gnt1       = req1_valid && (!req0_valid || !last_id_q);
    assign req0_ready = idle && req0_valid && !gnt1;
    assign req1_ready = idle && gnt1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_id_d  = last_id_q;
        core_enc_d = core_enc_q;
        core_k_d   = core_k_q;
        core_p_d   = core_p_q;
        core_t_d   = core_t_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    core_enc_d = req1_ready ? req1_enc   : req0_enc;
                    core_k_d   = req1_ready ? req1_key   : req0_key;
                    core_p_d   = req1_ready ? req1_pt    : req0_pt;
                    core_t_d   = req1_ready ? req1_tweak : req0_tweak;
                    rsp_id_d   = req1_ready;
                    last_id_d  = req1_ready;
                    cnt_d      = CNT_INIT;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d = core_C;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    core_k_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            last_id_q  <= 1'b1;
            core_enc_q <= 1'b0;
            core_k_q   <= '0;
            core_p_q   <= '0;
            core_t_q   <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_id_q  <= last_id_d;
            core_enc_q <= core_enc_d;
            core_k_q   <= core_k_d;
            core_p_q   <= core_p_d;
            core_t_q   <= core_t_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign core_enc  = core_enc_q;
    assign core_K    = core_k_q;
    assign core_P    = core_p_q;
    assign core_T    = core_t_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_qarma_sched.sv
// Bench for qarma_sched: stand-in core model, scoreboard of expected
// responses, two instances (WAIT_CYC=4 and WAIT_CYC=1).
module tb_qarma_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic         id;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];

    function automatic logic [127:0] qmodel(input logic enc, input logic [255:0] k,
                                            input logic [127:0] p, input logic [127:0] t);
        logic [127:0] w;
        w = k[127:0] ^ {t[63:0], t[127:64]};
        if (enc) return (p ^ w) + k[255:128] + 128'hC0AC29B7C97C50DD3F84D5B5B5470917;
        return ((p - k[255:128]) ^ w) ^ 128'h243F6A8885A308D313198A2E03707344;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // instance A: WAIT_CYC = 4
    logic         a_rst_n, a_r0v, a_r1v, a_r0r, a_r1r, a_r0e, a_r1e;
    logic [255:0] a_r0k, a_r1k, a_ck;
    logic [127:0] a_r0p, a_r1p, a_r0t, a_r1t, a_cp, a_ct, a_cc, a_rd;
    logic         a_ce, a_rv, a_rr, a_rid, a_bsy;

    assign a_cc = qmodel(a_ce, a_ck, a_cp, a_ct);

    qarma_sched #(.WAIT_CYC(4)) u_a (
        .clk(clk), .rst_n(a_rst_n),
        .req0_valid(a_r0v), .req0_ready(a_r0r), .req0_enc(a_r0e),
        .req0_key(a_r0k), .req0_pt(a_r0p), .req0_tweak(a_r0t),
        .req1_valid(a_r1v), .req1_ready(a_r1r), .req1_enc(a_r1e),
        .req1_key(a_r1k), .req1_pt(a_r1p), .req1_tweak(a_r1t),
        .core_enc(a_ce), .core_K(a_ck), .core_P(a_cp), .core_T(a_ct),
        .core_C(a_cc), .rsp_valid(a_rv), .rsp_ready(a_rr),
        .rsp_data(a_rd), .rsp_id(a_rid), .busy(a_bsy)
    );

    // instance B: WAIT_CYC = 1
    logic         b_rst_n, b_r0v, b_r1v, b_r0r, b_r1r, b_r0e, b_r1e;
    logic [255:0] b_r0k, b_r1k, b_ck;
    logic [127:0] b_r0p, b_r1p, b_r0t, b_r1t, b_cp, b_ct, b_cc, b_rd;
    logic         b_ce, b_rv, b_rr, b_rid, b_bsy;

    assign b_cc = qmodel(b_ce, b_ck, b_cp, b_ct);

    qarma_sched #(.WAIT_CYC(1)) u_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_r0v), .req0_ready(b_r0r), .req0_enc(b_r0e),
        .req0_key(b_r0k), .req0_pt(b_r0p), .req0_tweak(b_r0t),
        .req1_valid(b_r1v), .req1_ready(b_r1r), .req1_enc(b_r1e),
        .req1_key(b_r1k), .req1_pt(b_r1p), .req1_tweak(b_r1t),
        .core_enc(b_ce), .core_K(b_ck), .core_P(b_cp), .core_T(b_ct),
        .core_C(b_cc), .rsp_valid(b_rv), .rsp_ready(b_rr),
        .rsp_data(b_rd), .rsp_id(b_rid), .busy(b_bsy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_ops_a();
        a_r0e = 1'($urandom); a_r1e = 1'($urandom);
        a_r0k = {rnd128(), rnd128()}; a_r1k = {rnd128(), rnd128()};
        a_r0p = rnd128(); a_r1p = rnd128();
        a_r0t = rnd128(); a_r1t = rnd128();
    endtask

    task automatic accept_a(input logic id);
        exp_t e;
        chk("ready0", a_r0r, !id);
        chk("ready1", a_r1r, id);
        e.id = id;
        e.data = id ? qmodel(a_r1e, a_r1k, a_r1p, a_r1t)
                    : qmodel(a_r0e, a_r0k, a_r0p, a_r0t);
        sb.push_back(e);
        step();
        chk("busy_after_accept", a_bsy, 1'b1);
        chk("rv_after_accept", a_rv, 1'b0);
    endtask

    task automatic wait_rsp_a(output int n);
        n = 0;
        while (!a_rv && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic take_rsp_a();
        exp_t e;
        chk("sb_depth", 256'(sb.size()), 256'(1));
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk("rsp_valid", a_rv, 1'b1);
        chk("rsp_data", a_rd, e.data);
        chk("rsp_id", a_rid, e.id);
        a_rr = 1'b1;
        step();
        a_rr = 1'b0;
        chk("busy_after_rsp", a_bsy, 1'b0);
        chk("key_zeroized", a_ck, '0);
        chk("rsp_valid_low", a_rv, 1'b0);
        chk("rsp_data_held", a_rd, e.data);
    endtask

    initial begin
        int n;
        logic [127:0] cap_p;
        logic [127:0] exp_d;
        logic [255:0] key_b;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_r0v = 1'b0; a_r1v = 1'b0; a_rr = 1'b0;
        a_r0e = 1'b0; a_r1e = 1'b0;
        a_r0k = '0; a_r1k = '0; a_r0p = '0; a_r1p = '0; a_r0t = '0; a_r1t = '0;
        b_r0v = 1'b0; b_r1v = 1'b0; b_rr = 1'b0;
        b_r0e = 1'b0; b_r1e = 1'b0;
        b_r0k = '0; b_r1k = '0; b_r0p = '0; b_r1p = '0; b_r0t = '0; b_r1t = '0;
        repeat (2) step();

        // reset values, with a request already pending
        a_r0v = 1'b1; a_r0e = 1'b1;
        #1;
        chk("rst_ready0", a_r0r, 1'b0);
        chk("rst_busy", a_bsy, 1'b0);
        chk("rst_rv", a_rv, 1'b0);
        chk("rst_ck", a_ck, '0);
        chk("rst_cp", a_cp, '0);
        chk("rst_rd", a_rd, '0);
        chk("rst_rid", a_rid, 1'b0);

        // first edge with rst_n high accepts; zero operands, encrypt
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        #1;
        accept_a(1'b0);
        a_r0v = 1'b0;
        chk("core_enc", a_ce, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("latency4", a_rv, k == 4);
        end
        take_rsp_a();

        // contention from reset: order 0,1,0,1
        a_rst_n = 1'b0;
        #1;
        a_rst_n = 1'b1;
        a_r0v = 1'b1; a_r1v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd_ops_a();
            #1;
            accept_a(1'(i % 2));
            wait_rsp_a(n);
            chk("rr_latency", 256'(n), 256'(4));
            take_rsp_a();
        end

        // stalled response, operand change during WAIT
        a_r0v = 1'b0;
        rnd_ops_a();
        #1;
        cap_p = a_r1p;
        accept_a(1'b1);
        a_r1p = ~a_r1p;
        a_r0v = 1'b1;
        step();
        chk("cp_hold_wait", a_cp, cap_p);
        wait_rsp_a(n);
        chk("stall_latency", 256'(n), 256'(3));
        exp_d = (sb.size() > 0) ? sb[0].data : '0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_rv", a_rv, 1'b1);
            chk("stall_rd", a_rd, exp_d);
            chk("stall_rid", a_rid, 1'b1);
            chk("stall_cp", a_cp, cap_p);
            chk("stall_busy", a_bsy, 1'b1);
            chk("stall_readies", {a_r0r, a_r1r}, 2'b00);
            step();
        end
        take_rsp_a();
        a_r0v = 1'b0; a_r1v = 1'b0;

        // asynchronous reset two cycles into WAIT
        a_r0v = 1'b1;
        rnd_ops_a();
        #1;
        accept_a(1'b0);
        a_r0v = 1'b0;
        step();
        step();
        #2;
        a_rst_n = 1'b0;
        #1;
        chk("arst_rv", a_rv, 1'b0);
        chk("arst_busy", a_bsy, 1'b0);
        chk("arst_ck", a_ck, '0);
        chk("arst_cp", a_cp, '0);
        chk("arst_ct", a_ct, '0);
        chk("arst_ce", a_ce, 1'b0);
        chk("arst_rd", a_rd, '0);
        chk("arst_rid", a_rid, 1'b0);
        sb.delete();
        step();
        step();
        a_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("no_rsp_after_rst", a_rv, 1'b0);
        end
        a_r0v = 1'b1;
        rnd_ops_a();
        #1;
        accept_a(1'b0);
        a_r0v = 1'b0;
        wait_rsp_a(n);
        chk("post_rst_latency", 256'(n), 256'(4));
        take_rsp_a();

        // WAIT_CYC = 1 instance
        b_r1v = 1'b1;
        b_r1e = 1'b0;
        key_b = {rnd128(), rnd128()} | 256'h1;
        b_r1k = key_b;
        b_r1p = rnd128();
        b_r1t = rnd128();
        #1;
        chk("b_ready1", b_r1r, 1'b1);
        chk("b_ready0", b_r0r, 1'b0);
        exp_d = qmodel(b_r1e, b_r1k, b_r1p, b_r1t);
        cap_p = b_r1p;
        step();
        b_r1v = 1'b0;
        chk("b_rv_early", b_rv, 1'b0);
        step();
        chk("b_latency1", b_rv, 1'b1);
        chk("b_rd", b_rd, exp_d);
        chk("b_rid", b_rid, 1'b1);
        chk("b_ck_live", b_ck, key_b);
        b_rr = 1'b1;
        step();
        b_rr = 1'b0;
        chk("b_ck_zero", b_ck, '0);
        chk("b_cp_kept", b_cp, cap_p);
        chk("b_rv_low", b_rv, 1'b0);
        chk("b_rd_held", b_rd, exp_d);
        chk("b_busy", b_bsy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qarma_sched.md
QARMA_SCHED -- requirements
Module: qarma_sched

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 4, meaning clock cycles allowed for the combinational QARMA-128 core to settle; legal range 1..15.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester's operation is accepted this cycle.
REQ-006 SHALL have ports req0_enc / req1_enc  input  1  operation select: 1 = encrypt, 0 = decrypt.
REQ-007 SHALL have ports req0_key / req1_key  input  256  key.
REQ-008 SHALL have ports req0_pt / req1_pt  input  128  input block.
REQ-009 SHALL have ports req0_tweak / req1_tweak  input  128  tweak.
REQ-010 SHALL have ports core_enc / core_K / core_P / core_T  output  1/256/128/128  registered operands driven to the shared core.
REQ-011 SHALL have port core_C  input  128  core result.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts the result.
REQ-014 SHALL have port rsp_data  output  128  result block.
REQ-015 SHALL have port rsp_id  output  1  requester index the result belongs to.
REQ-016 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement the states IDLE, WAIT and RESP, with a 4-bit cycle counter cnt.
REQ-018 SHALL assert reqN_ready only when state is IDLE, reqN_valid is high and N holds the grant; at most one ready is high per cycle.
REQ-019 SHALL grant as follows when both requests are valid in IDLE: the requester not recorded in last_id wins (round-robin).
REQ-020 SHALL grant a single valid requester regardless of last_id.
REQ-021 SHALL, on an accept edge (reqN_valid & reqN_ready), load enc/key/pt/tweak into the core_* registers, set rsp_id=N and last_id=N, set cnt=WAIT_CYC-1, and enter WAIT.
REQ-022 SHALL hold core_* outputs constant throughout WAIT and RESP.
REQ-023 SHALL decrement cnt at each edge in WAIT while cnt!=0.
REQ-024 SHALL, at the WAIT edge where cnt==0, capture core_C into rsp_data and enter RESP.
REQ-025 SHALL give a fixed latency: rsp_valid rises exactly WAIT_CYC edges after the accept edge.
REQ-026 SHALL drive rsp_valid high in RESP only, and keep rsp_data/rsp_id stable while rsp_valid & !rsp_ready.
REQ-027 SHALL, on an edge with rsp_valid & rsp_ready, enter IDLE and clear core_K to zero (key zeroization); core_P/core_T/core_enc retain their values.
REQ-028 SHALL accept no request in the cycle RESP is left; minimum spacing between accepts is WAIT_CYC+2 cycles.
REQ-029 SHALL ignore request inputs and request changes outside IDLE; a requester deasserting valid before ready loses nothing.
REQ-030 SHALL hold rsp_data at its last value after the handshake, until the next capture.

Reset
REQ-031 SHALL, while rst_n is low, force: state IDLE; cnt 0; last_id 1 (so req0 wins the first contention); all core_* outputs 0; rsp_valid 0; rsp_data 0; rsp_id 0; busy 0; req0_ready and req1_ready 0.
REQ-032 SHALL, on reset asserted in WAIT or RESP, abandon the operation with no response emitted, and return to IDLE with the REQ-031 values.
REQ-033 SHALL release from reset with the first accept possible on the first rising edge at which rst_n is high.

Verification
REQ-034 SHALL cover: WAIT_CYC=4, req0 only (key=0, pt=0, tweak=0, enc=1), bench core model -> req0_ready one cycle; rsp_valid at 4th edge after accept; rsp_id=0; rsp_data=model output.
REQ-035 SHALL cover: both valid from reset -> req0 served first, then req1 on the next IDLE; with both held valid, order 0,1,0,1.
REQ-036 SHALL cover: rsp_ready held low 10 cycles -> rsp_valid, rsp_data, rsp_id and core_* stable; no readies asserted; busy=1.
REQ-037 SHALL cover: rst_n pulsed low 2 cycles after accept -> all outputs zero immediately (asynchronous); no rsp_valid afterward; next request served normally.
REQ-038 SHALL cover: WAIT_CYC=1 -> rsp_valid one edge after accept; core_K=0 the cycle after the response handshake.
REQ-039 SHALL cover: requester changes pt during WAIT -> core_P unchanged, and the result matches the operands captured at accept.
